// File: rtl/bus_grant_ctrl.sv
// Grants the bus to the arbiter-selected client, captures its word and offers it to the server (valid/ready); 4 cycles IDLE-to-IDLE minimum.
// Holds server_valid until server_ready; BUS_GRANT_TIMEOUT_EN builds a watchdog that aborts stalled transfers.
module bus_grant_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            address_to_be_served,
  input  logic                  client_1_rq,
  input  logic                  client_2_rq,
  input  logic                  client_3_rq,
  input  logic                  client_4_rq,
  input  logic [DATA_WIDTH-1:0] client_1_data,
  input  logic [DATA_WIDTH-1:0] client_2_data,
  input  logic [DATA_WIDTH-1:0] client_3_data,
  input  logic [DATA_WIDTH-1:0] client_4_data,
  output logic [3:0]            client_grant,
  output logic                  server_valid,
  output logic [DATA_WIDTH-1:0] server_data,
  output logic [1:0]            server_addr,
  input  logic                  server_ready,
  output logic                  server_ack,
  output logic                  timeout_err,
  output logic [15:0]           xfer_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_XFER, ST_ACK} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            w_rq;
  logic [DATA_WIDTH-1:0] w_data [4];
  logic                  w_timeout;

  logic [3:0]            r_grant;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_addr;
  logic                  r_ack;
  logic [15:0]           r_xfer_count;

  logic [3:0]            w_grant_nxt;
  logic                  w_valid_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic [1:0]            w_addr_nxt;
  logic                  w_ack_nxt;
  logic [15:0]           w_count_nxt;

  assign w_rq      = {client_4_rq, client_3_rq, client_2_rq, client_1_rq};
  assign w_data[0] = client_1_data;
  assign w_data[1] = client_2_data;
  assign w_data[2] = client_3_data;
  assign w_data[3] = client_4_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (enable && w_rq[address_to_be_served]) w_state_nxt = ST_GRANT;
      ST_GRANT: w_state_nxt = w_rq[r_addr] ? ST_XFER : ST_IDLE;
      ST_XFER: begin
        if (server_ready)   w_state_nxt = ST_ACK;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_ACK:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered without adding latency.
  always_comb begin
    w_addr_nxt  = (r_state == ST_IDLE && w_state_nxt == ST_GRANT) ? address_to_be_served : r_addr;
    w_grant_nxt = 4'b0000;
    if (w_state_nxt == ST_GRANT || w_state_nxt == ST_XFER) w_grant_nxt = 4'b0001 << w_addr_nxt;
    w_data_nxt  = (r_state == ST_GRANT && w_state_nxt == ST_XFER) ? w_data[r_addr] : r_data;
    w_valid_nxt = (w_state_nxt == ST_XFER);
    w_ack_nxt   = (w_state_nxt == ST_ACK);
    w_count_nxt = w_ack_nxt ? r_xfer_count + 16'd1 : r_xfer_count;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant      <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_addr       <= '0;
      r_ack        <= 1'b0;
      r_xfer_count <= '0;
    end else begin
      r_grant      <= w_grant_nxt;
      r_valid      <= w_valid_nxt;
      r_data       <= w_data_nxt;
      r_addr       <= w_addr_nxt;
      r_ack        <= w_ack_nxt;
      r_xfer_count <= w_count_nxt;
    end
  end

`ifdef BUS_GRANT_TIMEOUT_EN
  localparam logic [7:0] LP_WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wd_cnt;
  logic       r_timeout_err;

  // Counter sits at zero outside XFER, so every transfer starts with a fresh budget.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != ST_XFER) r_wd_cnt <= '0;
      else if (!server_ready) r_wd_cnt <= r_wd_cnt + 8'd1;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign w_timeout   = (r_state == ST_XFER) && !server_ready && (r_wd_cnt == LP_WD_LAST);
  assign timeout_err = r_timeout_err;
`else
  // Constant 0 for every legal TIMEOUT_CYCLES: XFER waits for the server indefinitely.
  assign w_timeout   = (TIMEOUT_CYCLES == 0);
  assign timeout_err = 1'b0;
`endif

  assign client_grant = r_grant;
  assign server_valid = r_valid;
  assign server_data  = r_data;
  assign server_addr  = r_addr;
  assign server_ack   = r_ack;
  assign xfer_count   = r_xfer_count;

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Directed bench for bus_grant_ctrl: stimulus pushes expected words/counts, a negedge monitor pops and compares.
module tb_bus_grant_ctrl;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    addr = 2'd0;
  logic [3:0]    rq = 4'b0000;
  logic [DW-1:0] cdata [4];
  logic          server_ready = 1'b0;

  logic [3:0]    client_grant;
  logic          server_valid;
  logic [DW-1:0] server_data;
  logic [1:0]    server_addr;
  logic          server_ack;
  logic          timeout_err;
  logic [15:0]   xfer_count;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    addr;
  } exp_t;

  exp_t        exp_q [$];
  logic [15:0] cnt_q [$];
  logic [15:0] exp_count = 16'd0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic          prev_valid = 1'b0;
  logic [DW-1:0] prev_data = '0;

  bus_grant_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(15)) dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .address_to_be_served (addr),
    .client_1_rq          (rq[0]),
    .client_2_rq          (rq[1]),
    .client_3_rq          (rq[2]),
    .client_4_rq          (rq[3]),
    .client_1_data        (cdata[0]),
    .client_2_data        (cdata[1]),
    .client_3_data        (cdata[2]),
    .client_4_data        (cdata[3]),
    .client_grant         (client_grant),
    .server_valid         (server_valid),
    .server_data          (server_data),
    .server_addr          (server_addr),
    .server_ready         (server_ready),
    .server_ack           (server_ack),
    .timeout_err          (timeout_err),
    .xfer_count           (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [1:0] a, input logic [DW-1:0] d, input logic rdy);
    addr         = a;
    rq           = 4'b0001 << a;
    cdata[a]     = d;
    server_ready = rdy;
    enable       = 1'b1;
  endtask

  task automatic push_exp(input logic [1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({d, a});
    exp_count = exp_count + 16'd1;
    cnt_q.push_back(exp_count);
  endtask

  task automatic wait_ack();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (server_ack) begin
        seen = 1'b1;
        break;
      end
    end
    chk("ack_within_budget", 32'(seen), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(client_grant), 32'd0);
    chk({tag, "_valid"}, 32'(server_valid), 32'd0);
    chk({tag, "_data"},  32'(server_data),  32'd0);
    chk({tag, "_addr"},  32'(server_addr),  32'd0);
    chk({tag, "_ack"},   32'(server_ack),   32'd0);
    chk({tag, "_err"},   32'(timeout_err),  32'd0);
    chk({tag, "_count"}, 32'(xfer_count),   32'd0);
  endtask

  // Scoreboard monitor: every accepted word and every ack is matched against the queues.
  always @(negedge clk) begin
    if (reset) begin
      if (server_valid && prev_valid)
        chk("data_stable_while_valid", 32'(server_data), 32'(prev_data));
      if (server_valid && server_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_xfer: got data 0x%0h addr %0d, required no transfer", server_data, server_addr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("xfer_data", 32'(server_data), 32'(e.data));
          chk("xfer_addr", 32'(server_addr), 32'(e.addr));
        end
      end
      if (server_ack) begin
        if (cnt_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack with count 0x%0h, required no ack", xfer_count);
        end else begin
          logic [15:0] c;
          c = cnt_q.pop_front();
          chk("ack_count", 32'(xfer_count), 32'(c));
        end
      end
    end
    prev_valid <= server_valid;
    prev_data  <= server_data;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) cdata[i] = '0;

    // Reset state
    #12;
    chk_all_zero("reset");
    step();
    reset = 1'b1;

    // Basic transfer, server always ready
    start_req(2'd2, 8'hA5, 1'b1);
    push_exp(2'd2, 8'hA5);
    @(posedge clk);
    @(negedge clk);
    chk("t1_grant_e1", 32'(client_grant), 32'h4);
    chk("t1_valid_e1", 32'(server_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_e2", 32'(server_valid), 32'd1);
    chk("t1_data_e2",  32'(server_data),  32'hA5);
    chk("t1_addr_e2",  32'(server_addr),  32'd2);
    chk("t1_grant_e2", 32'(client_grant), 32'h4);
    @(negedge clk);
    chk("t1_ack_e3",   32'(server_ack),   32'd1);
    chk("t1_grant_e3", 32'(client_grant), 32'd0);
    chk("t1_valid_e3", 32'(server_valid), 32'd0);
    chk("t1_count_e3", 32'(xfer_count),   32'd1);
    @(posedge clk);
    #1 rq = 4'b0000;
    @(negedge clk);
    chk("t1_ack_one_cycle", 32'(server_ack), 32'd0);
    step();

    // Address and a second request change after the grant edge; latched client wins
    start_req(2'd0, 8'h3C, 1'b1);
    push_exp(2'd0, 8'h3C);
    @(posedge clk);
    #1;
    addr     = 2'd3;
    cdata[3] = 8'h77;
    rq[3]    = 1'b1;
    wait_ack();
    chk("t1b_addr_held", 32'(server_addr), 32'd0);
    step();
    rq = 4'b0000;

    // Enable low blocks new grants
    enable = 1'b0;
    addr   = 2'd1;
    rq     = 4'b0010;
    cdata[1] = 8'h11;
    repeat (3) step();
    @(negedge clk);
    chk("en_low_grant", 32'(client_grant), 32'd0);
    chk("en_low_valid", 32'(server_valid), 32'd0);
    step();

    // Request drops during GRANT: abort, no ack
    enable = 1'b1;
    @(posedge clk);
    #1 rq = 4'b0000;
    @(negedge clk);
    chk("t2_grant", 32'(client_grant), 32'h2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_no_valid", 32'(server_valid), 32'd0);
      chk("t2_no_ack",   32'(server_ack),   32'd0);
    end
    chk("t2_count", 32'(xfer_count), 32'(exp_count));
    step();

    // Server stalls 5 XFER cycles; request drops during XFER
    start_req(2'd3, 8'h5A, 1'b0);
    push_exp(2'd3, 8'h5A);
    @(posedge clk);
    @(posedge clk);
    #1 rq = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_valid_held", 32'(server_valid), 32'd1);
      chk("t3_data_held",  32'(server_data),  32'h5A);
      @(posedge clk);
    end
    #1 server_ready = 1'b1;
    wait_ack();
    chk("t3_no_err", 32'(timeout_err), 32'd0);
    step();

`ifdef BUS_GRANT_TIMEOUT_EN
    // Server stuck: abort after 15 XFER cycles
    start_req(2'd0, 8'hC3, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rq = 4'b0000;
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("t4_valid_cycle15", 32'(server_valid), 32'd1);
    chk("t4_err_cycle15",   32'(timeout_err),  32'd0);
    @(negedge clk);
    chk("t4_valid_abort", 32'(server_valid), 32'd0);
    chk("t4_err_set",     32'(timeout_err),  32'd1);
    chk("t4_grant_abort", 32'(client_grant), 32'd0);
    chk("t4_count",       32'(xfer_count),   32'(exp_count));
    step();
    start_req(2'd1, 8'h96, 1'b1);
    push_exp(2'd1, 8'h96);
    wait_ack();
    chk("t4_err_sticky", 32'(timeout_err), 32'd1);
    step();
    rq = 4'b0000;
`else
    // No watchdog: a stalled server is waited on indefinitely
    start_req(2'd0, 8'hC3, 1'b0);
    push_exp(2'd0, 8'hC3);
    @(posedge clk);
    @(posedge clk);
    #1 rq = 4'b0000;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t4_still_valid", 32'(server_valid), 32'd1);
    chk("t4_no_err",      32'(timeout_err),  32'd0);
    step();
    server_ready = 1'b1;
    wait_ack();
    step();
`endif

    // Asynchronous reset during XFER
    start_req(2'd2, 8'h4B, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk_all_zero("t5_async");
    exp_count = 16'd0;
    step();
    reset = 1'b1;
    rq    = 4'b0000;
    @(negedge clk);
    chk("t5_idle_grant", 32'(client_grant), 32'd0);
    step();
    start_req(2'd2, 8'h4B, 1'b1);
    push_exp(2'd2, 8'h4B);
    wait_ack();
    step();
    rq = 4'b0000;

    // Counter wrap from 0xFFFF
    force dut.r_xfer_count = 16'hFFFF;
    #1 release dut.r_xfer_count;
    exp_count = 16'hFFFF;
    @(negedge clk);
    chk("t6_preload", 32'(xfer_count), 32'hFFFF);
    step();
    start_req(2'd1, 8'hE7, 1'b1);
    push_exp(2'd1, 8'hE7);
    wait_ack();
    chk("t6_wrap", 32'(xfer_count), 32'd0);
    step();
    rq = 4'b0000;

    repeat (3) step();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("cnt_q_drained", 32'(cnt_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_grant_ctrl.md
# bus_grant_ctrl

Downstream stage of the round-robin arbiter. It takes the arbiter's selected client address and the raw client requests, grants the bus to that client, captures the client's data word, and presents it to the server through a valid/ready handshake. When the server accepts the word, it returns a one-cycle `server_ack` to the arbiter so the ring rotates. An optional watchdog aborts transfers the server never accepts.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: width of each client data word and of `server_data`.
- `TIMEOUT_CYCLES`, default 15: maximum number of XFER cycles without `server_ready`. Range 1..255.

Ports:
- `clk` input 1: single clock; everything is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `enable` input 1: when low, no new grant is started; a transfer already in progress completes.
- `address_to_be_served` input 2: arbiter selection (0..3 = client 1..4).
- `client_1_rq` … `client_4_rq` input 1 each: client requests.
- `client_1_data` … `client_4_data` input DATA_WIDTH each: client data words.
- `client_grant` output 4: one-hot grant; bit i is client i+1.
- `server_valid` output 1: `server_data` and `server_addr` are valid.
- `server_data` output DATA_WIDTH: captured client word.
- `server_addr` output 2: address of the granted client.
- `server_ready` input 1: server accepts the word.
- `server_ack` output 1: one-cycle pulse to the arbiter on a successful transfer.
- `timeout_err` output 1: sticky watchdog flag.
- `xfer_count` output 16: count of successful transfers.

## Operation

- FSM states: IDLE, GRANT, XFER, ACK. Binary encoded. Reset state is IDLE.
- IDLE:
  - If `enable` is high and the request of the client selected by `address_to_be_served` is high, latch the address into `server_addr` and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (1 cycle): `client_grant` is one-hot at the latched address.
  - If the granted client's request is still high, capture its data into the holding register and go to XFER.
  - If that request has dropped, abort to IDLE with no ack.
- XFER: `server_valid` is 1. `server_data` and `server_addr` stay stable and `client_grant` stays asserted.
  - `server_ready` high → go to ACK.
- ACK (1 cycle):
  - `server_ack` is 1 and `client_grant` is 0.
  - `xfer_count` increments by 1 and wraps from 0xFFFF to 0.
  - Next state is IDLE.
- A client request dropping during XFER is ignored; the captured word is still delivered.
- Changes on `address_to_be_served` after the IDLE→GRANT edge are ignored until the block returns to IDLE.
- Watchdog, when built:
  - An 8-bit counter clears on entry to XFER and increments on each XFER cycle with `server_ready` low.
  - When it reaches `TIMEOUT_CYCLES` with `server_ready` still low, go to IDLE, set `timeout_err`, and do not assert `server_ack`.
  - If `server_ready` is high in the same cycle the limit is reached, `server_ready` wins: go to ACK, no error.
  - `timeout_err` is cleared only by reset.
- Reset asserted mid-transfer immediately returns the block to IDLE and clears all outputs; no ack is issued.
- All outputs are registered.

## Timing

- Reset values:
  - `client_grant` = 0, `server_valid` = 0, `server_data` = 0, `server_addr` = 0.
  - `server_ack` = 0, `timeout_err` = 0, `xfer_count` = 0.
- Let edge E be the rising edge at which IDLE samples a qualifying request.
- `client_grant` asserts after edge E.
- `server_valid` asserts after edge E+1.
- If `server_ready` is held high, ACK occurs after edge E+2 and IDLE is re-entered after edge E+3. Minimum transfer time is 4 cycles IDLE-to-IDLE.
- Back-to-back transfers: the IDLE cycle after ACK can start the next grant. Sustained throughput is 1 word per 4 cycles.
- `server_valid` never deasserts without a `server_ready` handshake, except on timeout or reset.

## Configuration

- `BUS_GRANT_TIMEOUT_EN` defined: the watchdog counter and `timeout_err` logic are built as described.
- Not defined:
  - XFER waits indefinitely for `server_ready`.
  - `timeout_err` is tied to 0.
  - `TIMEOUT_CYCLES` is unused.

## Test plan

- Reset release; `address_to_be_served`=2, `client_3_rq`=1, `client_3_data`=0xA5, `server_ready` tied 1:
  - `client_grant`=4'b0100 at E+1.
  - `server_valid`=1 with `server_data`=0xA5 and `server_addr`=2 at E+2.
  - `server_ack` pulses 1 cycle at E+3.
  - `xfer_count`=1.
- `client_2_rq` drops during GRANT → return to IDLE; `server_valid` stays 0, no `server_ack`, `xfer_count` unchanged.
- `server_ready` held low for 5 XFER cycles, then high → `server_data` is stable throughout, one ack, `timeout_err`=0.
- With `BUS_GRANT_TIMEOUT_EN` and `TIMEOUT_CYCLES`=15, `server_ready` stuck low:
  - Abort after 15 XFER cycles with `timeout_err`=1 and no ack.
  - The next request completes normally and `timeout_err` stays 1.
- `reset` pulsed low during XFER → all outputs return to 0 asynchronously and the FSM restarts in IDLE.
- Preload `xfer_count` to 0xFFFF via 65535 transfers (or force), then one transfer → `xfer_count`=0x0000.
